// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the slave-side response multiplexer and its default slave.
package ahb_pkg;

  localparam int unsigned NUM_PORTS = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SEL_W     = NUM_PORTS + 1;
  localparam int unsigned DFLT_IDX  = NUM_PORTS;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    DFLT_IDLE = 2'b00,
    DFLT_ERR1 = 2'b01,
    DFLT_ERR2 = 2'b10
  } dflt_state_e;

  // One slave's data-phase response as seen by the mux.
  typedef struct packed {
    logic              ready;
    logic              resp;
    logic [DATA_W-1:0] rdata;
  } ahb_rsp_t;

  // True for transfers that carry data (NONSEQ/SEQ).
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_dflt_resp.sv
// Default slave: answers unclaimed active transfers with a two-cycle ERROR,
// idle/busy transfers with a zero-wait OKAY.
module ahb_dflt_resp
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  dflt_state_e state;
  dflt_state_e state_nxt;
  logic        req;

  assign req = HSEL & is_active(HTRANS) & HREADY;

  // State register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= DFLT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and response; ERR2 may directly accept a new request.
  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      DFLT_IDLE: begin
        state_nxt = req ? DFLT_ERR1 : DFLT_IDLE;
      end
      DFLT_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nxt = DFLT_ERR2;
      end
      DFLT_ERR2: begin
        HRESP     = HRESP_ERROR;
        state_nxt = req ? DFLT_ERR1 : DFLT_IDLE;
      end
      default: begin
        state_nxt = DFLT_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ahb_slave_mux_dflt.sv
// AHB slave response multiplexer with up to ten slave ports and a built-in
// default slave that claims any unselected address phase.
module ahb_slave_mux_dflt
  import ahb_pkg::*;
#(
  parameter int unsigned PORT0_ENABLE = 1,
  parameter int unsigned PORT1_ENABLE = 1,
  parameter int unsigned PORT2_ENABLE = 0,
  parameter int unsigned PORT3_ENABLE = 0,
  parameter int unsigned PORT4_ENABLE = 0,
  parameter int unsigned PORT5_ENABLE = 0,
  parameter int unsigned PORT6_ENABLE = 0,
  parameter int unsigned PORT7_ENABLE = 0,
  parameter int unsigned PORT8_ENABLE = 0,
  parameter int unsigned PORT9_ENABLE = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic              HSEL0,
  input  logic              HSEL1,
  input  logic              HSEL2,
  input  logic              HSEL3,
  input  logic              HSEL4,
  input  logic              HSEL5,
  input  logic              HSEL6,
  input  logic              HSEL7,
  input  logic              HSEL8,
  input  logic              HSEL9,
  input  logic              HREADYOUT0,
  input  logic              HREADYOUT1,
  input  logic              HREADYOUT2,
  input  logic              HREADYOUT3,
  input  logic              HREADYOUT4,
  input  logic              HREADYOUT5,
  input  logic              HREADYOUT6,
  input  logic              HREADYOUT7,
  input  logic              HREADYOUT8,
  input  logic              HREADYOUT9,
  input  logic              HRESP0,
  input  logic              HRESP1,
  input  logic              HRESP2,
  input  logic              HRESP3,
  input  logic              HRESP4,
  input  logic              HRESP5,
  input  logic              HRESP6,
  input  logic              HRESP7,
  input  logic              HRESP8,
  input  logic              HRESP9,
  input  logic [DATA_W-1:0] HRDATA0,
  input  logic [DATA_W-1:0] HRDATA1,
  input  logic [DATA_W-1:0] HRDATA2,
  input  logic [DATA_W-1:0] HRDATA3,
  input  logic [DATA_W-1:0] HRDATA4,
  input  logic [DATA_W-1:0] HRDATA5,
  input  logic [DATA_W-1:0] HRDATA6,
  input  logic [DATA_W-1:0] HRDATA7,
  input  logic [DATA_W-1:0] HRDATA8,
  input  logic [DATA_W-1:0] HRDATA9,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam logic [NUM_PORTS-1:0] PORT_EN = {
    PORT9_ENABLE != 0, PORT8_ENABLE != 0, PORT7_ENABLE != 0, PORT6_ENABLE != 0,
    PORT5_ENABLE != 0, PORT4_ENABLE != 0, PORT3_ENABLE != 0, PORT2_ENABLE != 0,
    PORT1_ENABLE != 0, PORT0_ENABLE != 0
  };

  localparam logic [SEL_W-1:0] SEL_DFLT = {1'b1, {NUM_PORTS{1'b0}}};

  logic [NUM_PORTS-1:0] hsel_v;
  logic [NUM_PORTS-1:0] sel_a;
  logic [NUM_PORTS-1:0] sel_pri;
  logic                 dsel;
  logic [SEL_W-1:0]     dsel_q;
  ahb_rsp_t             port_rsp [NUM_PORTS];
  ahb_rsp_t             rsp_mux;
  logic                 dflt_ready;
  logic                 dflt_resp;

  assign hsel_v = {HSEL9, HSEL8, HSEL7, HSEL6, HSEL5,
                   HSEL4, HSEL3, HSEL2, HSEL1, HSEL0};

  assign port_rsp[0] = '{ready: HREADYOUT0, resp: HRESP0, rdata: HRDATA0};
  assign port_rsp[1] = '{ready: HREADYOUT1, resp: HRESP1, rdata: HRDATA1};
  assign port_rsp[2] = '{ready: HREADYOUT2, resp: HRESP2, rdata: HRDATA2};
  assign port_rsp[3] = '{ready: HREADYOUT3, resp: HRESP3, rdata: HRDATA3};
  assign port_rsp[4] = '{ready: HREADYOUT4, resp: HRESP4, rdata: HRDATA4};
  assign port_rsp[5] = '{ready: HREADYOUT5, resp: HRESP5, rdata: HRDATA5};
  assign port_rsp[6] = '{ready: HREADYOUT6, resp: HRESP6, rdata: HRDATA6};
  assign port_rsp[7] = '{ready: HREADYOUT7, resp: HRESP7, rdata: HRDATA7};
  assign port_rsp[8] = '{ready: HREADYOUT8, resp: HRESP8, rdata: HRDATA8};
  assign port_rsp[9] = '{ready: HREADYOUT9, resp: HRESP9, rdata: HRDATA9};

  // Address-phase select: mask disabled ports, keep only the lowest set bit.
  assign sel_a   = hsel_v & PORT_EN;
  assign sel_pri = sel_a & (~sel_a + NUM_PORTS'(1));
  assign dsel    = (sel_a == '0);

  // Data-phase owner advances only when the bus accepts the address phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_q <= SEL_DFLT;
    end else if (HREADY) begin
      dsel_q <= {dsel, sel_pri};
    end
  end

  ahb_dflt_resp u_dflt (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (dsel),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (dflt_ready),
    .HRESP     (dflt_resp)
  );

  // Response mux; a disabled owner always reports ready so the bus cannot stall.
  always_comb begin
    rsp_mux = '{ready: dflt_ready, resp: dflt_resp, rdata: '0};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dsel_q[i]) begin
        if (PORT_EN[i]) begin
          rsp_mux = port_rsp[i];
        end else begin
          rsp_mux = '{ready: 1'b1, resp: HRESP_OKAY, rdata: '0};
        end
      end
    end
  end

  assign HREADYOUT = rsp_mux.ready;
  assign HRESP     = rsp_mux.resp;
  assign HRDATA    = rsp_mux.rdata;

endmodule

// File: tb/tb_ahb_slave_mux_dflt.sv
// Scoreboard bench for ahb_slave_mux_dflt (default parameters: ports 0 and 1 connected).
module tb_ahb_slave_mux_dflt;

  typedef struct {
    logic        ready;
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        hready;
  logic [1:0]  htrans;
  logic [9:0]  hsel;
  logic [9:0]  rdy;
  logic [9:0]  rsp;
  logic [31:0] rdata [10];
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  int   total;
  int   bad;
  exp_t sb_q [$];

  // Reference model: who owns the data phase, and how many error cycles remain.
  int   m_owner;
  int   m_err_left;
  bit   m_en [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

  assign hready = hreadyout;

  ahb_slave_mux_dflt dut (
    .HCLK(clk), .HRESET(rst), .HREADY(hready), .HTRANS(htrans),
    .HSEL0(hsel[0]), .HSEL1(hsel[1]), .HSEL2(hsel[2]), .HSEL3(hsel[3]), .HSEL4(hsel[4]),
    .HSEL5(hsel[5]), .HSEL6(hsel[6]), .HSEL7(hsel[7]), .HSEL8(hsel[8]), .HSEL9(hsel[9]),
    .HREADYOUT0(rdy[0]), .HREADYOUT1(rdy[1]), .HREADYOUT2(rdy[2]), .HREADYOUT3(rdy[3]),
    .HREADYOUT4(rdy[4]), .HREADYOUT5(rdy[5]), .HREADYOUT6(rdy[6]), .HREADYOUT7(rdy[7]),
    .HREADYOUT8(rdy[8]), .HREADYOUT9(rdy[9]),
    .HRESP0(rsp[0]), .HRESP1(rsp[1]), .HRESP2(rsp[2]), .HRESP3(rsp[3]), .HRESP4(rsp[4]),
    .HRESP5(rsp[5]), .HRESP6(rsp[6]), .HRESP7(rsp[7]), .HRESP8(rsp[8]), .HRESP9(rsp[9]),
    .HRDATA0(rdata[0]), .HRDATA1(rdata[1]), .HRDATA2(rdata[2]), .HRDATA3(rdata[3]),
    .HRDATA4(rdata[4]), .HRDATA5(rdata[5]), .HRDATA6(rdata[6]), .HRDATA7(rdata[7]),
    .HRDATA8(rdata[8]), .HRDATA9(rdata[9]),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT against the queued expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("hreadyout", 32'(hreadyout), 32'(e.ready));
      check("hresp",     32'(hresp),     32'(e.resp));
      check("hrdata",    hrdata,         e.rdata);
    end
  end

  // Issue one cycle of the currently driven inputs; queue expectation, advance model.
  task automatic step();
    exp_t e;
    int   low;
    if (m_owner == 10) begin
      e.ready = (m_err_left != 2);
      e.resp  = (m_err_left > 0);
      e.rdata = 32'h0;
    end else begin
      e.ready = rdy[m_owner];
      e.resp  = rsp[m_owner];
      e.rdata = rdata[m_owner];
    end
    sb_q.push_back(e);
    low = 10;
    for (int i = 9; i >= 0; i--) if (hsel[i] && m_en[i]) low = i;
    if (m_err_left > 0) m_err_left--;
    if (e.ready) begin
      if (low == 10 && htrans[1]) m_err_left = 2;
      m_owner = low;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cycle(input logic [9:0] s, input logic [1:0] t);
    hsel   = s;
    htrans = t;
    rdy    = '1;
    rsp    = '0;
    for (int i = 0; i < 10; i++) rdata[i] = $urandom;
  endtask

  task automatic model_reset();
    m_owner    = 10;
    m_err_left = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    rst = 1'b1;
    set_cycle(10'h0, 2'b00);
    #12;
    check("reset_ready", 32'(hreadyout), 32'h1);
    check("reset_resp",  32'(hresp),     32'h0);
    check("reset_rdata", hrdata,         32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Port 0 NONSEQ, then data phase returns A5A5A5A5.
    set_cycle(10'h001, 2'b10); step();
    set_cycle(10'h000, 2'b00); rdata[0] = 32'hA5A5A5A5; step();

    // Port 0 stalls three cycles while HSEL1 toggles.
    set_cycle(10'h001, 2'b10); step();
    for (int k = 0; k < 3; k++) begin
      set_cycle(10'(k % 2 == 0 ? 2 : 0), 2'b10);
      rdy[0] = 1'b0;
      step();
    end
    set_cycle(10'h000, 2'b00); step();

    // Unclaimed NONSEQ: two-cycle error then idle.
    set_cycle(10'h000, 2'b10); step();
    for (int k = 0; k < 4; k++) begin set_cycle(10'h000, 2'b00); step(); end

    // Unclaimed IDLE / BUSY: zero-wait OKAY.
    for (int k = 0; k < 3; k++) begin set_cycle(10'h000, 2'(k % 2)); step(); end

    // Priority between ports 0 and 1.
    set_cycle(10'h003, 2'b10); step();
    set_cycle(10'h000, 2'b00); rdata[0] = 32'h1; rdata[1] = 32'h2; step();

    // Disabled port 2 falls to the default slave.
    set_cycle(10'h004, 2'b10); step();
    for (int k = 0; k < 3; k++) begin set_cycle(10'h000, 2'b00); step(); end

    // Back-to-back error: new request accepted during the second error cycle.
    set_cycle(10'h000, 2'b11); step();
    set_cycle(10'h000, 2'b00); step();
    set_cycle(10'h000, 2'b10); step();
    for (int k = 0; k < 3; k++) begin set_cycle(10'h000, 2'b00); step(); end

    // Reset asserted during the first error cycle.
    set_cycle(10'h000, 2'b10); step();
    set_cycle(10'h000, 2'b00);
    #2;
    check("err1_before_reset_ready", 32'(hreadyout), 32'h0);
    check("err1_before_reset_resp",  32'(hresp),     32'h1);
    rst = 1'b1;
    #1;
    check("async_reset_ready", 32'(hreadyout), 32'h1);
    check("async_reset_resp",  32'(hresp),     32'h0);
    check("async_reset_rdata", hrdata,         32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    set_cycle(10'h000, 2'b00); step();
    set_cycle(10'h000, 2'b00); step();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      hsel   = ($urandom_range(0, 3) == 0) ? 10'h0 : 10'($urandom);
      htrans = 2'($urandom);
      rdy    = ~(10'($urandom) & 10'($urandom));
      rsp    = 10'($urandom) & 10'($urandom) & 10'($urandom);
      for (int i = 0; i < 10; i++) rdata[i] = $urandom;
      step();
    end

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
